gpio_mmio: RTL and testbench
============================

# gpio_mmio

Memory-mapped GPIO peripheral inside `soc`, sitting between the CPU data bus and the board pins. It debounces the `switches` inputs into a CPU-readable register and drives `leds` from a CPU-writable register. With the edge-capture option compiled in, it also latches switch changes into a sticky register and raises a maskable interrupt.

## Interface
- `DIV`, 16: clock cycles per debounce sample tick, ≥2.
- `STABLE`, 3: consecutive ticks a bit must differ from its debounced value before it is accepted, ≥1.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `sel` input 1: peripheral selected by the CPU address decode.
- `we` input 1: write strobe, valid only when `sel`=1.
- `addr` input 2: register select. 0 LED (RW), 1 SW (RO), 2 EDGE (W1C), 3 MASK (RW).
- `wdata` input 16: write data.
- `rdata` output 16: read data.
- `switches` input 16: raw, asynchronous pin inputs.
- `leds` output 16: LED drive, equal to the LED register.
- `irq` output 1: interrupt request.

## Operation
- Reset clears all of the following to 0: LED, the debounced SW value, EDGE, MASK, the prescaler, the synchronizer flops and the per-bit counters. Consequently `leds`=0, `irq`=0 and `rdata`=0.
- **Synchronizer:** each `switches` bit passes through 2 flops, giving `sw_sync`.
- **Prescaler:** counts 0 to DIV-1 and wraps. `tick` is asserted for one cycle when the count equals DIV-1.
- **Debounce, evaluated per bit on each tick:**
  - If `sw_sync` equals the debounced value, the bit's counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter would reach STABLE, the debounced value takes `sw_sync` and the counter clears.
  - Any tick on which the input matches the debounced value restarts the count, so glitches shorter than STABLE ticks are rejected.
- **Bus writes** take effect when `sel`=1 and `we`=1, on the next rising edge:
  - addr 0: LED takes `wdata`.
  - addr 1: ignored.
  - addr 2: EDGE bits written with 1 are cleared.
  - addr 3: MASK takes `wdata`.
- **Bus reads:** `rdata` is combinational from the addressed register. When `sel`=0, `rdata` is 0.
- **EDGE register:** a bit is set in the cycle its debounced value changes, in either direction.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- `irq` = OR-reduction of (EDGE AND MASK), driven combinationally from registers.
- Switches held high through reset are treated as real changes. Their debounced bits rise after the first qualifying period and set EDGE; this is intended.

## Timing
- LED write: `leds` changes on the rising edge that samples the write.
- MASK write: `irq` reflects the new mask on that same edge.
- Switch to SW latency: 2 synchronizer cycles, then STABLE ticks. The worst case is 2 + DIV·STABLE cycles, depending on prescaler phase.
- EDGE sets and `irq` rises on the same edge that the SW bit updates.
- Reset asserted mid-debounce discards all partial counts immediately.
- Read-after-write to the same register in the next cycle returns the new value.

## Configuration
- `GPIO_EDGE_IRQ_EN` defined: the EDGE and MASK registers and `irq` logic are built as described above.
- `GPIO_EDGE_IRQ_EN` undefined:
  - EDGE and MASK are not implemented.
  - Reads of addr 2 and addr 3 return 0, and writes to them are ignored.
  - `irq` is tied to 0.
  - LED, SW and debounce behaviour is unchanged.

## Test plan
All scenarios use DIV=4, STABLE=3.
- **Reset state:** hold `rst`=1 with `switches`=16'hFFFF → `leds`=0, SW reads 0, `irq`=0. After release, SW reads 16'hFFFF within 2+12 cycles and EDGE reads 16'hFFFF.
- **LED write/read:** write 16'hA5C3 to addr 0 → `leds`=16'hA5C3 on the next edge, and a read of addr 0 returns 16'hA5C3. A write of 16'h1234 to addr 1 leaves SW unchanged.
- **Glitch rejection:**
  - Pulse `switches[0]` high for 6 cycles (under 3 ticks) → SW[0] stays 0 and EDGE[0] stays 0.
  - Hold it high for 20 cycles → SW[0]=1 and EDGE[0]=1.
- **Interrupt masking:**
  - With MASK=0, change `switches[5]` → EDGE[5]=1 and `irq`=0.
  - Write MASK=16'h0020 → `irq`=1.
  - Write 16'h0020 to addr 2 → EDGE[5]=0 and `irq`=0.
- **Set-beats-clear:** issue a W1C of EDGE[3] in the exact cycle SW[3] toggles → EDGE[3] reads 1 afterwards.
- **Mid-debounce reset:** assert `rst` 2 ticks after `switches[7]` rises → after release, SW[7] updates only after a fresh 2+3-tick period.

Source files
------------

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: debounced switch register, LED register, and (with
// GPIO_EDGE_IRQ_EN defined) a sticky edge-capture register with maskable irq.
module gpio_mmio #(
    parameter int DIV    = 16,
    parameter int STABLE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        irq
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (STABLE > 0) ? $clog2(STABLE + 1) : 1;

    logic [15:0]   sw_meta;
    logic [15:0]   sw_sync;
    logic [PW-1:0] presc;
    logic          tick;
    logic [15:0]   sw_deb;
    logic [15:0]   sw_next;
    logic [CW-1:0] cnt      [16];
    logic [CW-1:0] cnt_next [16];
    logic [15:0]   led_reg;
    logic          wr;

    assign wr   = sel & we;
    assign tick = (presc == PW'(DIV - 1));
    assign leds = led_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
            presc   <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            presc   <= tick ? '0 : presc + PW'(1);
        end
    end

    // A bit is accepted only after STABLE consecutive disagreeing ticks;
    // any agreeing tick restarts its count.
    always_comb begin
        sw_next = sw_deb;
        for (int i = 0; i < 16; i++) begin
            cnt_next[i] = cnt[i];
            if (tick) begin
                if (sw_sync[i] == sw_deb[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CW'(STABLE - 1)) begin
                    sw_next[i]  = sw_sync[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_deb <= '0;
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
        end else begin
            sw_deb <= sw_next;
            for (int i = 0; i < 16; i++) cnt[i] <= cnt_next[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_reg <= '0;
        end else if (wr && addr == 2'd0) begin
            led_reg <= wdata;
        end
    end

`ifdef GPIO_EDGE_IRQ_EN
    logic [15:0] edge_reg;
    logic [15:0] mask_reg;
    logic [15:0] edge_clr;

    assign edge_clr = (wr && addr == 2'd2) ? wdata : 16'h0000;

    // New debounced changes are OR-ed in after the W1C so a same-cycle set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_reg <= '0;
            mask_reg <= '0;
        end else begin
            edge_reg <= (edge_reg & ~edge_clr) | (sw_next ^ sw_deb);
            if (wr && addr == 2'd3) mask_reg <= wdata;
        end
    end

    assign irq = |(edge_reg & mask_reg);
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd0:    rdata = led_reg;
                2'd1:    rdata = sw_deb;
`ifdef GPIO_EDGE_IRQ_EN
                2'd2:    rdata = edge_reg;
                2'd3:    rdata = mask_reg;
`endif
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_mmio.sv
// Self-checking bench for gpio_mmio with DIV=4, STABLE=3; edge/irq expectations
// follow whether GPIO_EDGE_IRQ_EN is defined.
module tb_gpio_mmio;

`ifdef GPIO_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] switches;
    logic [15:0] leds;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int cyc;

    gpio_mmio #(.DIV(4), .STABLE(3)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .switches(switches),
        .leds(leds), .irq(irq)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; a prescaler tick lands on edges where cyc%4 becomes 0.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [15:0] exp_leds;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] en16(logic [15:0] v);
        return EDGE_EN ? v : 16'h0000;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] a, output logic [15:0] d);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic alignTick;
        while (cyc % 4 != 0) cycles(1);
    endtask

    task automatic applyStimulus(input vec_t v);
        sel = v.sel; we = v.we; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1;
        we = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;

        vecs[0] = '{1'b1, 1'b1, 2'd0, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 16'h1234, 16'h0000, 16'hA5C3, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 2'd0, 16'hFFFF, 16'h0000, 16'hA5C3, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'hA5C3, 16'hA5C3, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'd3, 16'h00F0, en16(16'h00F0), 16'hA5C3, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 16'hFFFF, 16'h0000, 16'hA5C3, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 16'h5A3C, 16'h5A3C, 16'h5A3C, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'd3, 16'h0000, 16'h0000, 16'h5A3C, 1'b0};

        rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = '0;
        switches = 16'hFFFF;

        // Reset state with switches held high
        cycles(3);
        checkOutput("reset_leds", leds, 16'h0000);
        checkOutput("reset_irq", {15'd0, irq}, 16'h0000);
        busRead(2'd1, r); checkOutput("reset_sw", r, 16'h0000);
        busRead(2'd2, r); checkOutput("reset_edge", r, 16'h0000);
        busRead(2'd3, r); checkOutput("reset_mask", r, 16'h0000);
        rst = 1'b0;
        cycles(11);
        busRead(2'd1, r); checkOutput("sw_before_latency", r, 16'h0000);
        cycles(1);
        busRead(2'd1, r); checkOutput("sw_after_latency", r, 16'hFFFF);
        busRead(2'd2, r); checkOutput("edge_after_reset", r, en16(16'hFFFF));
        checkOutput("irq_masked_after_reset", {15'd0, irq}, 16'h0000);
        checkOutput("rdata_unselected", rdata, 16'h0000);

        switches = 16'h0000;
        cycles(20);
        busRead(2'd1, r); checkOutput("sw_fall", r, 16'h0000);
        busWrite(2'd2, 16'hFFFF);
        busRead(2'd2, r); checkOutput("edge_w1c_all", r, 16'h0000);

        // Bus register vectors
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_leds", i), leds, vecs[i].exp_leds);
            checkOutput($sformatf("vec%0d_irq", i), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
            sel = 1'b0;
        end

        // Glitch rejection then genuine press on bit 0
        switches = 16'h0001;
        cycles(6);
        switches = 16'h0000;
        cycles(20);
        busRead(2'd1, r); checkOutput("glitch_sw", r, 16'h0000);
        busRead(2'd2, r); checkOutput("glitch_edge", r, 16'h0000);
        switches = 16'h0001;
        cycles(20);
        busRead(2'd1, r); checkOutput("hold_sw", r, 16'h0001);
        busRead(2'd2, r); checkOutput("hold_edge", r, en16(16'h0001));

        // Interrupt masking on bit 5
        busWrite(2'd2, 16'hFFFF);
        switches = 16'h0021;
        cycles(20);
        busRead(2'd2, r); checkOutput("mask0_edge", r, en16(16'h0020));
        checkOutput("mask0_irq", {15'd0, irq}, 16'h0000);
        busWrite(2'd3, 16'h0020);
        checkOutput("mask_irq_on", {15'd0, irq}, {15'd0, EDGE_EN});
        busWrite(2'd2, 16'h0020);
        busRead(2'd2, r); checkOutput("w1c_edge5", r, 16'h0000);
        checkOutput("w1c_irq_off", {15'd0, irq}, 16'h0000);

        // Set-beats-clear: W1C of bit 3 lands on the edge SW[3] rises
        alignTick();
        switches = 16'h0029;
        cycles(11);
        busRead(2'd1, r); checkOutput("sbc_sw_before", r, 16'h0021);
        busRead(2'd2, r); checkOutput("sbc_edge_before", r, 16'h0000);
        busWrite(2'd2, 16'h0008);
        busRead(2'd1, r); checkOutput("sbc_sw_after", r, 16'h0029);
        busRead(2'd2, r); checkOutput("sbc_edge_after", r, en16(16'h0008));
        busWrite(2'd2, 16'h0008);
        busRead(2'd2, r); checkOutput("sbc_edge_cleared", r, 16'h0000);

        // Reset two ticks into the debounce of bit 7
        alignTick();
        switches = 16'h00A9;
        cycles(9);
        rst = 1'b1;
        #1;
        busRead(2'd1, r); checkOutput("midrst_sw", r, 16'h0000);
        checkOutput("midrst_leds", leds, 16'h0000);
        cycles(3);
        rst = 1'b0;
        cycles(11);
        busRead(2'd1, r); checkOutput("midrst_sw_early", r, 16'h0000);
        cycles(1);
        busRead(2'd1, r); checkOutput("midrst_sw_fresh", r, 16'h00A9);
        busRead(2'd2, r); checkOutput("midrst_edge", r, en16(16'h00A9));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
